// File: rtl/exec_pkg.sv
// Shared types for the WISC execute stage: opcode/branch encodings and FSM states.
package exec_pkg;

  localparam int DEST_W = 3;

  // Seventeen named ALU functions do not fit a 4-bit opcode. Pass-through of
  // bsel has no code point here: decode issues OR with the a operand forced to 0.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_ANDN = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_ROL  = 4'd9,
    ALU_ROR  = 4'd10,
    ALU_SEQ  = 4'd11,
    ALU_SLT  = 4'd12,
    ALU_SLE  = 4'd13,
    ALU_SCO  = 4'd14,
    ALU_MUL  = 4'd15
  } aluop_t;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQZ = 3'd1,
    BR_BNEZ = 3'd2,
    BR_BLTZ = 3'd3,
    BR_BGEZ = 3'd4,
    BR_JMP  = 3'd5,
    BR_JR   = 3'd6
  } brop_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Shift-amount width for a given datapath width.
  function automatic int shw(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/execute_pipe_if.sv
// Decode-side and memory-side handshakes of the execute stage, plus flush and redirect.
interface execute_pipe_if import exec_pkg::*; #(parameter int WIDTH = 16);

  logic              in_valid;
  logic              in_ready;
  aluop_t            in_aluop;
  brop_t             in_brop;
  logic              in_alu_src;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [WIDTH-1:0]  in_imm;
  logic [WIDTH-1:0]  in_pc_plus_2;
  logic [DEST_W-1:0] in_dest;
  logic              in_wen;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  logic [DEST_W-1:0] out_dest;
  logic              out_wen;
  logic              redirect_valid;
  logic [WIDTH-1:0]  redirect_pc;

  // Execute stage view.
  modport slave (
    input  in_valid, in_aluop, in_brop, in_alu_src, in_a, in_b, in_imm,
           in_pc_plus_2, in_dest, in_wen, flush, out_ready,
    output in_ready, out_valid, out_result, out_dest, out_wen,
           redirect_valid, redirect_pc
  );

  // Decode / memory / fetch view.
  modport master (
    output in_valid, in_aluop, in_brop, in_alu_src, in_a, in_b, in_imm,
           in_pc_plus_2, in_dest, in_wen, flush, out_ready,
    input  in_ready, out_valid, out_result, out_dest, out_wen,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits kept.
module exec_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_step;

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  // done marks the cycle in which the final partial product is being added.
  assign done     = busy_q & (cnt_q == CW'(WIDTH - 1));
  assign product  = acc_q;

  // Operand latch on start, one shift-add step per cycle while busy; abort discards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_pipe.sv
// WISC execute stage: combinational ALU/branch, iterative MUL, registered EX/MEM slot.
//
// state | meaning
// IDLE  | accepting ops; non-MUL results go straight into the slot
// MUL   | multiplier stepping, input stalled
// WAIT  | product ready, waiting for the slot to be free
module execute_pipe import exec_pkg::*; #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  execute_pipe_if.slave pipe
);

  localparam int SHW = shw(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bsel;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     sum_ext;
  logic [2*WIDTH-1:0] rot_l, rot_r;
  logic [WIDTH-1:0]   alu_res;
  logic               br_taken;
  logic [WIDTH-1:0]   br_target;
  logic               slot_free, in_ready_c, accept, is_mul;
  logic               mul_start, load_alu, load_mul, mul_abort;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_product;
  logic [DEST_W-1:0]  mul_dest_q;
  logic               mul_wen_q;

  assign bsel    = pipe.in_alu_src ? pipe.in_imm : pipe.in_b;
  assign shamt   = bsel[SHW-1:0];
  assign sum_ext = {1'b0, pipe.in_a} + {1'b0, bsel};
  assign rot_l   = {pipe.in_a, pipe.in_a} << shamt;
  assign rot_r   = {pipe.in_a, pipe.in_a} >> shamt;

  // ALU function select; MUL here only covers the MUL_EN=0 single-cycle zero.
  always_comb begin
    alu_res = '0;
    case (pipe.in_aluop)
      ALU_ADD:  alu_res = sum_ext[WIDTH-1:0];
      ALU_SUB:  alu_res = bsel - pipe.in_a;
      ALU_AND:  alu_res = pipe.in_a & bsel;
      ALU_OR:   alu_res = pipe.in_a | bsel;
      ALU_XOR:  alu_res = pipe.in_a ^ bsel;
      ALU_ANDN: alu_res = pipe.in_a & ~bsel;
      ALU_SLL:  alu_res = pipe.in_a << shamt;
      ALU_SRL:  alu_res = pipe.in_a >> shamt;
      ALU_SRA:  alu_res = $signed(pipe.in_a) >>> shamt;
      ALU_ROL:  alu_res = rot_l[2*WIDTH-1:WIDTH];
      ALU_ROR:  alu_res = rot_r[WIDTH-1:0];
      ALU_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, pipe.in_a == bsel};
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(pipe.in_a) <  $signed(bsel)};
      ALU_SLE:  alu_res = {{(WIDTH-1){1'b0}}, $signed(pipe.in_a) <= $signed(bsel)};
      ALU_SCO:  alu_res = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH]};
      ALU_MUL:  alu_res = '0;
      default:  alu_res = '0;
    endcase
  end

  // Branch condition on a; JR is the only register-relative target.
  always_comb begin
    br_taken  = 1'b0;
    br_target = pipe.in_pc_plus_2 + pipe.in_imm;
    case (pipe.in_brop)
      BR_BEQZ: br_taken = (pipe.in_a == '0);
      BR_BNEZ: br_taken = (pipe.in_a != '0);
      BR_BLTZ: br_taken = pipe.in_a[WIDTH-1];
      BR_BGEZ: br_taken = !pipe.in_a[WIDTH-1];
      BR_JMP:  br_taken = 1'b1;
      BR_JR: begin
        br_taken  = 1'b1;
        br_target = pipe.in_a + pipe.in_imm;
      end
      default: br_taken = 1'b0;
    endcase
  end

  assign slot_free     = !pipe.out_valid | pipe.out_ready;
  assign in_ready_c    = (state_q == ST_IDLE) & slot_free & !pipe.flush;
  assign pipe.in_ready = in_ready_c;
  assign accept        = pipe.in_valid & in_ready_c;
  // A branch always takes the single-cycle path so the link value lands immediately.
  assign is_mul        = MUL_EN && (pipe.in_aluop == ALU_MUL) && (pipe.in_brop == BR_NONE);
  assign mul_start     = accept & is_mul;
  assign load_alu      = accept & !is_mul;
  assign mul_abort     = pipe.flush & (state_q != ST_IDLE);

  // Next state and multiplier-result slot load.
  always_comb begin
    state_d  = state_q;
    load_mul = 1'b0;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL: begin
        if (pipe.flush)    state_d = ST_IDLE;
        else if (mul_done) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pipe.flush) begin
          state_d = ST_IDLE;
        end else if (slot_free) begin
          load_mul = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  generate
    if (MUL_EN) begin : g_mul
      exec_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (mul_abort),
        .a       (pipe.in_a),
        .b       (bsel),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // Destination of an in-flight MUL, held until its product reaches the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_dest_q <= '0;
      mul_wen_q  <= 1'b0;
    end else if (mul_start) begin
      mul_dest_q <= pipe.in_dest;
      mul_wen_q  <= pipe.in_wen;
    end
  end

  // EX/MEM slot: load wins over drain, data frozen while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe.out_valid  <= 1'b0;
      pipe.out_result <= '0;
      pipe.out_dest   <= '0;
      pipe.out_wen    <= 1'b0;
    end else if (load_alu) begin
      pipe.out_valid  <= 1'b1;
      pipe.out_result <= (pipe.in_brop != BR_NONE) ? pipe.in_pc_plus_2 : alu_res;
      pipe.out_dest   <= pipe.in_dest;
      pipe.out_wen    <= pipe.in_wen;
    end else if (load_mul) begin
      pipe.out_valid  <= 1'b1;
      pipe.out_result <= mul_product;
      pipe.out_dest   <= mul_dest_q;
      pipe.out_wen    <= mul_wen_q;
    end else if (pipe.out_ready) begin
      pipe.out_valid  <= 1'b0;
    end
  end

  // One-cycle redirect pulse for taken branches and jumps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe.redirect_valid <= 1'b0;
      pipe.redirect_pc    <= '0;
    end else begin
      pipe.redirect_valid <= accept & br_taken;
      if (accept & br_taken) pipe.redirect_pc <= br_target;
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe (WIDTH=16, MUL_EN=1) with hand-computed expectations.
module tb_execute_pipe;
  import exec_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cnt;

  execute_pipe_if #(.WIDTH(16)) bus ();

  execute_pipe #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input aluop_t op, input brop_t br, input logic src,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] imm, input logic [15:0] pc2,
                       input logic [2:0] dest);
    bus.in_valid     = 1'b1;
    bus.in_aluop     = op;
    bus.in_brop      = br;
    bus.in_alu_src   = src;
    bus.in_a         = a;
    bus.in_b         = b;
    bus.in_imm       = imm;
    bus.in_pc_plus_2 = pc2;
    bus.in_dest      = dest;
    bus.in_wen       = 1'b1;
  endtask

  aluop_t      v_op  [8] = '{ALU_SRA, ALU_ROL, ALU_SLT, ALU_SUB, ALU_ROR, ALU_ANDN, ALU_SLE, ALU_SLL};
  logic        v_src [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] v_a   [8] = '{16'h8000, 16'h8001, 16'hFFFF, 16'h0003, 16'h0001, 16'hF0F0, 16'h0005, 16'h0003};
  logic [15:0] v_b   [8] = '{16'h000F, 16'h0001, 16'h0001, 16'h0010, 16'h0001, 16'hFF00, 16'h0005, 16'h0000};
  logic [15:0] v_imm [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004};
  logic [15:0] v_exp [8] = '{16'hFFFF, 16'h0003, 16'h0001, 16'h000D, 16'h8000, 16'h00F0, 16'h0001, 16'h0030};

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_aluop = ALU_ADD; bus.in_brop = BR_NONE;
    bus.in_alu_src = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_imm = '0;
    bus.in_pc_plus_2 = '0; bus.in_dest = '0; bus.in_wen = 1'b0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (2) tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_dest", bus.out_dest, 0);
    check("rst_out_wen", bus.out_wen, 0);
    check("rst_redir_valid", bus.redirect_valid, 0);
    check("rst_redir_pc", bus.redirect_pc, 0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    // ADD then SCO back to back
    drive(ALU_ADD, BR_NONE, 1'b1, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 3'd3);
    tick();
    check("add_valid", bus.out_valid, 1);
    check("add_result", bus.out_result, 16'h8000);
    check("add_dest", bus.out_dest, 3);
    check("add_wen", bus.out_wen, 1);
    drive(ALU_SCO, BR_NONE, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 3'd4);
    tick();
    check("sco_valid", bus.out_valid, 1);
    check("sco_result", bus.out_result, 16'h0001);
    check("sco_dest", bus.out_dest, 4);

    // Full-throughput stream of shifts, compares and logic ops
    for (int i = 0; i < 8; i++) begin
      drive(v_op[i], BR_NONE, v_src[i], v_a[i], v_b[i], v_imm[i], 16'h0000, 3'(i));
      tick();
      check($sformatf("vec%0d_valid", i), bus.out_valid, 1);
      check($sformatf("vec%0d_result", i), bus.out_result, v_exp[i]);
    end

    // Branches
    drive(ALU_ADD, BR_BEQZ, 1'b0, 16'h0000, 16'h0000, 16'hFFFC, 16'h0010, 3'd1);
    tick();
    check("beqz_t_redir", bus.redirect_valid, 1);
    check("beqz_t_pc", bus.redirect_pc, 16'h000C);
    check("beqz_t_link", bus.out_result, 16'h0010);
    drive(ALU_ADD, BR_BEQZ, 1'b0, 16'h0005, 16'h0000, 16'hFFFC, 16'h0020, 3'd1);
    tick();
    check("beqz_nt_redir", bus.redirect_valid, 0);
    check("beqz_nt_link", bus.out_result, 16'h0020);
    drive(ALU_XOR, BR_JR, 1'b0, 16'h0100, 16'h0000, 16'h0004, 16'h0030, 3'd7);
    tick();
    check("jr_redir", bus.redirect_valid, 1);
    check("jr_pc", bus.redirect_pc, 16'h0104);
    check("jr_link", bus.out_result, 16'h0030);
    bus.in_valid = 1'b0;
    tick();
    check("jr_pulse_end", bus.redirect_valid, 0);
    check("drain_valid", bus.out_valid, 0);

    // MUL latency
    drive(ALU_MUL, BR_NONE, 1'b0, 16'h0123, 16'h0010, 16'h0000, 16'h0000, 3'd5);
    tick();
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.in_ready && cnt < 40) begin
      cnt++;
      tick();
    end
    check("mul_stall_cycles", cnt, 17);
    check("mul_valid", bus.out_valid, 1);
    check("mul_result", bus.out_result, 16'h1230);
    check("mul_dest", bus.out_dest, 5);
    tick();
    check("mul_drain", bus.out_valid, 0);

    // Backpressure, then drain and load on the same edge
    bus.out_ready = 1'b0;
    drive(ALU_ADD, BR_NONE, 1'b1, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 3'd2);
    tick();
    check("bp_valid", bus.out_valid, 1);
    check("bp_result", bus.out_result, 16'h0002);
    drive(ALU_XOR, BR_NONE, 1'b0, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 3'd6);
    #1;
    check("bp_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_result", bus.out_result, 16'h0002);
      check("bp_hold_dest", bus.out_dest, 2);
      check("bp_hold_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    tick();
    check("bp_next_valid", bus.out_valid, 1);
    check("bp_next_result", bus.out_result, 16'h0006);
    check("bp_next_dest", bus.out_dest, 6);
    bus.in_valid = 1'b0;
    tick();
    check("bp_drain", bus.out_valid, 0);

    // Flush at MUL cycle 5
    drive(ALU_MUL, BR_NONE, 1'b0, 16'h0003, 16'h0003, 16'h0000, 16'h0000, 3'd1);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_no_out", bus.out_valid, 0);
    repeat (20) tick();
    check("flush_no_late_out", bus.out_valid, 0);

    // Reset at MUL cycle 3
    drive(ALU_ADD, BR_JMP, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0040, 3'd2);
    tick();
    check("jmp_redir", bus.redirect_valid, 1);
    check("jmp_pc", bus.redirect_pc, 16'h0050);
    check("jmp_link", bus.out_result, 16'h0040);
    drive(ALU_MUL, BR_NONE, 1'b0, 16'h0007, 16'h0009, 16'h0000, 16'h0000, 3'd3);
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    check("pre_rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_result", bus.out_result, 0);
    check("midrst_dest", bus.out_dest, 0);
    check("midrst_wen", bus.out_wen, 0);
    check("midrst_redir_pc", bus.redirect_pc, 0);
    check("midrst_redir", bus.redirect_valid, 0);
    tick();
    rst = 1'b1;
    repeat (20) tick();
    check("post_rst_no_out", bus.out_valid, 0);
    check("post_rst_ready", bus.in_ready, 1);

    // Fresh MUL after reset
    drive(ALU_MUL, BR_NONE, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 3'd4);
    tick();
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.in_ready && cnt < 40) begin
      cnt++;
      tick();
    end
    check("mul2_stall_cycles", cnt, 17);
    check("mul2_result", bus.out_result, 16'h0001);
    check("mul2_dest", bus.out_dest, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
